// File: rtl/nrisc_mem_pkg.sv
// Shared definitions for the NRISC shared-data RAM arbiter: core count,
// RAM geometry, FSM state encoding and a core-index decode helper.
package nrisc_mem_pkg;

    localparam int NCORES = 2;
    localparam int LMEM   = 8;
    localparam int TAM    = 16;
    localparam int CORE_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Decode a core index into its one-hot request/ack position.
    function automatic logic [NCORES-1:0] core_onehot(input logic [CORE_W-1:0] idx);
        if (idx == 1'b1) begin
            core_onehot = 2'b10;
        end else begin
            core_onehot = 2'b01;
        end
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Bundle of core-side handshake signals and RAM-side bus signals for the
// shared-data RAM arbiter. The lock vector exists only when SHMEM_ARB_LOCK_EN
// is defined.
interface shared_mem_arbiter_if;
    import nrisc_mem_pkg::*;

    logic [NCORES-1:0] req;
    logic [NCORES-1:0] we;
    logic [LMEM-1:0]   addr0;
    logic [LMEM-1:0]   addr1;
    logic [TAM-1:0]    wdata0;
    logic [TAM-1:0]    wdata1;
    logic [NCORES-1:0] ack;
    logic [TAM-1:0]    rdata0;
    logic [TAM-1:0]    rdata1;
    logic              mem_en;
    logic              mem_we;
    logic [LMEM-1:0]   mem_addr;
    logic [TAM-1:0]    mem_wdata;
    logic [TAM-1:0]    mem_rdata;

`ifdef SHMEM_ARB_LOCK_EN
    logic [NCORES-1:0] lock;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata, lock,
        output ack, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_rdata, lock,
        input  ack, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );
`else
    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational two-way round-robin picker. A lone requester wins; on a tie
// the core that was not granted last wins, giving strict alternation.
module rr_pick
    import nrisc_mem_pkg::*;
(
    input  logic [NCORES-1:0] req_masked,
    input  logic [CORE_W-1:0] last_gnt,
    output logic              valid,
    output logic [CORE_W-1:0] gnt_idx
);

    // Select the winning core index from the masked request vector.
    always_comb begin
        valid = |req_masked;
        case (req_masked)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_gnt;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous RAM
// between two NRISC cores with a clocked req/ack handshake.
// Timing: the grant edge registers mem_*, the RAM samples mem_en on the next
// edge, and the RESP edge registers ack together with the captured read data
// so rdata is valid in the same cycle ack is seen.
// Optional feature macro: SHMEM_ARB_LOCK_EN (bus lock for atomic RMW).
module shared_mem_arbiter
    import nrisc_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    shared_mem_arbiter_if.slave bus
);

    arb_state_e        state_r;
    logic [CORE_W-1:0] gnt_r;
    logic              gnt_we_r;
    logic [CORE_W-1:0] last_gnt_r;
    logic [NCORES-1:0] ack_r;
    logic [TAM-1:0]    rdata0_r;
    logic [TAM-1:0]    rdata1_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [LMEM-1:0]   mem_addr_r;
    logic [TAM-1:0]    mem_wdata_r;

    logic [NCORES-1:0] excl_s;
    logic [NCORES-1:0] lock_mask_s;
    logic [NCORES-1:0] req_masked_s;
    logic              pick_valid_s;
    logic [CORE_W-1:0] pick_idx_s;
    logic              grant_s;
    logic              pick_we_s;
    logic [LMEM-1:0]   pick_addr_s;
    logic [TAM-1:0]    pick_wdata_s;

`ifdef SHMEM_ARB_LOCK_EN
    logic              lock_act_r;
    logic [CORE_W-1:0] lock_owner_r;
    logic              gnt_lock_r;
    logic              lock_act_nxt_s;
    logic              pick_lock_s;
`endif

    // Build the candidate mask: drop the core being acknowledged, and while a
    // lock is held (and not released by this RESP) admit only the lock owner.
    always_comb begin
        if (state_r == ST_RESP) begin
            excl_s = core_onehot(gnt_r);
        end else begin
            excl_s = 2'b00;
        end
`ifdef SHMEM_ARB_LOCK_EN
        if ((state_r == ST_RESP) && lock_act_r && (lock_owner_r == gnt_r) && !gnt_lock_r) begin
            lock_act_nxt_s = 1'b0;
        end else begin
            lock_act_nxt_s = lock_act_r;
        end
        if (lock_act_nxt_s) begin
            lock_mask_s = core_onehot(lock_owner_r);
        end else begin
            lock_mask_s = 2'b11;
        end
`else
        lock_mask_s = 2'b11;
`endif
        req_masked_s = bus.req & ~excl_s & lock_mask_s;
    end

    rr_pick u_pick (
        .req_masked (req_masked_s),
        .last_gnt   (last_gnt_r),
        .valid      (pick_valid_s),
        .gnt_idx    (pick_idx_s)
    );

    // Route the picked core's request fields and decide whether a grant happens now.
    always_comb begin
        if (pick_idx_s == 1'b1) begin
            pick_we_s    = bus.we[1];
            pick_addr_s  = bus.addr1;
            pick_wdata_s = bus.wdata1;
`ifdef SHMEM_ARB_LOCK_EN
            pick_lock_s  = bus.lock[1];
`endif
        end else begin
            pick_we_s    = bus.we[0];
            pick_addr_s  = bus.addr0;
            pick_wdata_s = bus.wdata0;
`ifdef SHMEM_ARB_LOCK_EN
            pick_lock_s  = bus.lock[0];
`endif
        end
        if ((state_r == ST_IDLE) || (state_r == ST_RESP)) begin
            grant_s = pick_valid_s;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Arbitration FSM with registered RAM strobes, acks and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            gnt_r        <= 1'b0;
            gnt_we_r     <= 1'b0;
            last_gnt_r   <= 1'b1;
            ack_r        <= 2'b00;
            rdata0_r     <= 16'h0000;
            rdata1_r     <= 16'h0000;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 8'h00;
            mem_wdata_r  <= 16'h0000;
`ifdef SHMEM_ARB_LOCK_EN
            lock_act_r   <= 1'b0;
            lock_owner_r <= 1'b0;
            gnt_lock_r   <= 1'b0;
`endif
        end else begin
            ack_r    <= 2'b00;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    ack_r      <= core_onehot(gnt_r);
                    last_gnt_r <= gnt_r;
                    if (!gnt_we_r) begin
                        if (gnt_r == 1'b1) begin
                            rdata1_r <= bus.mem_rdata;
                        end else begin
                            rdata0_r <= bus.mem_rdata;
                        end
                    end
`ifdef SHMEM_ARB_LOCK_EN
                    lock_act_r <= lock_act_nxt_s;
`endif
                    if (pick_valid_s) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (grant_s) begin
                gnt_r       <= pick_idx_s;
                gnt_we_r    <= pick_we_s;
                mem_en_r    <= 1'b1;
                mem_we_r    <= pick_we_s;
                mem_addr_r  <= pick_addr_s;
                mem_wdata_r <= pick_wdata_s;
`ifdef SHMEM_ARB_LOCK_EN
                gnt_lock_r  <= pick_lock_s;
                if (pick_lock_s) begin
                    lock_act_r   <= 1'b1;
                    lock_owner_r <= pick_idx_s;
                end
`endif
            end
        end
    end

    assign bus.ack       = ack_r;
    assign bus.rdata0    = rdata0_r;
    assign bus.rdata1    = rdata1_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule
